// File: rtl/sudoku_pkg.sv
// Shared sudoku geometry, writer state encoding and board helpers.
// Both the board writer and the pixel generator import this package, so the geometry is defined once.
package sudoku_pkg;

    localparam int N_CELL     = 9;
    localparam int CELL_SIZE  = 52;
    localparam int BOARD_W    = 480;
    localparam int N_CELLS    = N_CELL * N_CELL;
    localparam int BOARD_BITS = 4 * N_CELLS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MAP      = 2'd1,
        ST_SELECTED = 2'd2,
        ST_WRITE    = 2'd3
    } wr_state_t;

    // Pixel offset of cell k; grid lines sit in the gaps between entries.
    function automatic logic [9:0] blk_pos(input logic [3:0] k);
        logic [9:0] pos;
        case (k)
            4'd0:    pos = 10'd0;
            4'd1:    pos = 10'd53;
            4'd2:    pos = 10'd106;
            4'd3:    pos = 10'd161;
            4'd4:    pos = 10'd214;
            4'd5:    pos = 10'd267;
            4'd6:    pos = 10'd322;
            4'd7:    pos = 10'd375;
            4'd8:    pos = 10'd428;
            default: pos = 10'd0;
        endcase
        return pos;
    endfunction

    function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return ({3'd0, row} * 7'd9) + {3'd0, col};
    endfunction

    function automatic logic [3:0] get_nibble(input logic [BOARD_BITS-1:0] b, input logic [6:0] idx);
        return b[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [BOARD_BITS-1:0] set_nibble(input logic [BOARD_BITS-1:0] b,
                                                         input logic [6:0] idx,
                                                         input logic [3:0] val);
        logic [BOARD_BITS-1:0] r;
        r = b;
        r[{idx, 2'b00} +: 4] = val;
        return r;
    endfunction

    // Values above 9 cannot be drawn, so a preload turns them into blanks.
    function automatic logic [BOARD_BITS-1:0] sanitize_board(input logic [BOARD_BITS-1:0] b);
        logic [BOARD_BITS-1:0] r;
        r = b;
        for (int i = 0; i < N_CELLS; i++) begin
            if (r[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd0;
            end
        end
        return r;
    endfunction

    function automatic logic [BOARD_BITS-1:0] clear_editable(input logic [BOARD_BITS-1:0] b,
                                                             input logic [N_CELLS-1:0] blank);
        logic [BOARD_BITS-1:0] r;
        r = b;
        for (int i = 0; i < N_CELLS; i++) begin
            if (blank[i]) begin
                r[i*4 +: 4] = 4'd0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sudoku_board_writer_if.sv
// Control/data bundle between the game controller (master) and the board writer (slave).
interface sudoku_board_writer_if;
    import sudoku_pkg::*;

    logic                   click;
    logic [9:0]             mouse_x;
    logic [9:0]             mouse_y;
    logic                   digit_valid;
    logic [3:0]             digit;
    logic                   clear;
    logic                   load_valid;
    logic [BOARD_BITS-1:0]  init_board;
    logic [N_CELLS-1:0]     init_given;
    logic [BOARD_BITS-1:0]  board;
    logic [N_CELLS-1:0]     board_blank;
    logic                   sel_valid;
    logic [3:0]             sel_row;
    logic [3:0]             sel_col;
    logic                   busy;
    logic                   write_ack;
    logic                   write_err;

    modport master (
        output click, mouse_x, mouse_y, digit_valid, digit, clear, load_valid, init_board, init_given,
        input  board, board_blank, sel_valid, sel_row, sel_col, busy, write_ack, write_err
    );

    modport slave (
        input  click, mouse_x, mouse_y, digit_valid, digit, clear, load_valid, init_board, init_given,
        output board, board_blank, sel_valid, sel_row, sel_col, busy, write_ack, write_err
    );

endinterface

// File: rtl/sudoku_coord_mapper.sv
// Sequential screen-to-cell mapper: tests one cell offset per cycle on both axes,
// then pulses done with the hit flags and indices.
module sudoku_coord_mapper
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       done,
    output logic       row_hit,
    output logic       col_hit,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [9:0] x_r, y_r;
    logic [3:0] k_r;
    logic       active_r, done_r, row_hit_r, col_hit_r;
    logic [3:0] row_r, col_r;
    logic [9:0] pos_s;
    logic       row_match_s, col_match_s;

    // Window test of the latched point against cell k on each axis.
    always_comb begin
        pos_s       = blk_pos(k_r);
        row_match_s = (y_r >= pos_s) && (y_r < pos_s + 10'(CELL_SIZE));
        col_match_s = (x_r >= pos_s) && (x_r < pos_s + 10'(CELL_SIZE)) && (x_r < 10'(BOARD_W));
    end

    // Iteration counter and hit capture; done is registered one edge after k = 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= 10'd0;
            y_r       <= 10'd0;
            k_r       <= 4'd0;
            active_r  <= 1'b0;
            done_r    <= 1'b0;
            row_hit_r <= 1'b0;
            col_hit_r <= 1'b0;
            row_r     <= 4'd0;
            col_r     <= 4'd0;
        end else if (abort) begin
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            x_r       <= x;
            y_r       <= y;
            k_r       <= 4'd0;
            active_r  <= 1'b1;
            done_r    <= 1'b0;
            row_hit_r <= 1'b0;
            col_hit_r <= 1'b0;
        end else if (active_r) begin
            if (row_match_s) begin
                row_hit_r <= 1'b1;
                row_r     <= k_r;
            end
            if (col_match_s) begin
                col_hit_r <= 1'b1;
                col_r     <= k_r;
            end
            if (k_r == 4'(N_CELL - 1)) begin
                active_r <= 1'b0;
                done_r   <= 1'b1;
            end else begin
                k_r    <= k_r + 4'd1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done    = done_r;
    assign row_hit = row_hit_r;
    assign col_hit = col_hit_r;
    assign row     = row_r;
    assign col     = col_r;

endmodule

// File: rtl/sudoku_board_writer.sv
// Board writer FSM: preload, clear, click-to-cell selection and digit commit
// into the packed board vectors read by the display.
module sudoku_board_writer
    import sudoku_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sudoku_board_writer_if.slave  bus
);

    wr_state_t              state_r;
    logic [BOARD_BITS-1:0]  board_r;
    logic [N_CELLS-1:0]     blank_r;
    logic                   sel_valid_r, busy_r, ack_r, err_r;
    logic [3:0]             sel_row_r, sel_col_r, digit_r;
    logic [6:0]             idx_r;

    logic                   idle_or_sel_s, start_s, wr_ok_s;
    logic                   map_done_s, row_hit_s, col_hit_s;
    logic [3:0]             map_row_s, map_col_s;

    // Accept a click only when nothing of higher priority claims the cycle.
    always_comb begin
        idle_or_sel_s = (state_r == ST_IDLE) || (state_r == ST_SELECTED);
        if (bus.click && idle_or_sel_s && !bus.load_valid && !bus.clear) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if (blank_r[idx_r] && (digit_r <= 4'd9)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    sudoku_coord_mapper u_mapper (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .abort   (bus.load_valid),
        .x       (bus.mouse_x),
        .y       (bus.mouse_y),
        .done    (map_done_s),
        .row_hit (row_hit_s),
        .col_hit (col_hit_s),
        .row     (map_row_s),
        .col     (map_col_s)
    );

    // Writer FSM with all visible outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            board_r     <= {BOARD_BITS{1'b0}};
            blank_r     <= {N_CELLS{1'b1}};
            sel_valid_r <= 1'b0;
            sel_row_r   <= 4'd0;
            sel_col_r   <= 4'd0;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            digit_r     <= 4'd0;
            idx_r       <= 7'd0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (bus.load_valid) begin
                board_r     <= sanitize_board(bus.init_board);
                blank_r     <= ~bus.init_given;
                sel_valid_r <= 1'b0;
                busy_r      <= 1'b0;
                state_r     <= ST_IDLE;
            end else if (bus.clear && idle_or_sel_s) begin
                board_r <= clear_editable(board_r, blank_r);
            end else if (start_s) begin
                busy_r  <= 1'b1;
                state_r <= ST_MAP;
            end else if (bus.digit_valid && (state_r == ST_SELECTED)) begin
                digit_r <= bus.digit;
                idx_r   <= cell_idx(sel_row_r, sel_col_r);
                state_r <= ST_WRITE;
            end else begin
                case (state_r)
                    ST_MAP: begin
                        if (map_done_s) begin
                            busy_r <= 1'b0;
                            if (row_hit_s && col_hit_s) begin
                                sel_row_r   <= map_row_s;
                                sel_col_r   <= map_col_s;
                                sel_valid_r <= 1'b1;
                                state_r     <= ST_SELECTED;
                            end else begin
                                sel_valid_r <= 1'b0;
                                state_r     <= ST_IDLE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (wr_ok_s) begin
                            board_r <= set_nibble(board_r, idx_r, digit_r);
                            ack_r   <= 1'b1;
                        end else begin
                            err_r   <= 1'b1;
                        end
                        state_r <= ST_SELECTED;
                    end
                    ST_IDLE:     state_r <= ST_IDLE;
                    ST_SELECTED: state_r <= ST_SELECTED;
                    default:     state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.board       = board_r;
    assign bus.board_blank = blank_r;
    assign bus.sel_valid   = sel_valid_r;
    assign bus.sel_row     = sel_row_r;
    assign bus.sel_col     = sel_col_r;
    assign bus.busy        = busy_r;
    assign bus.write_ack   = ack_r;
    assign bus.write_err   = err_r;

endmodule

// File: tb/tb_sudoku_board_writer.sv
// Randomised bench for sudoku_board_writer against a cell-array reference model.
module tb_sudoku_board_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sudoku_board_writer_if bus();
    sudoku_board_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    int m_board [81];
    bit m_given [81];
    bit m_sel;
    int m_row, m_col;
    int pos_tab [9] = '{0, 53, 106, 161, 214, 267, 322, 375, 428};
    logic [80:0] all_ones = 81'h1FFFFFFFFFFFFFFFFFFFF;

    // ---------------- reference model ----------------
    function automatic int axis_cell(int v, int limit);
        for (int k = 0; k < 9; k++)
            if (v >= pos_tab[k] && v < pos_tab[k] + 52 && v < limit) return k;
        return -1;
    endfunction

    function automatic logic [323:0] exp_board();
        logic [323:0] b;
        b = '0;
        for (int i = 0; i < 81; i++) b[i*4 +: 4] = 4'(m_board[i]);
        return b;
    endfunction

    function automatic logic [80:0] exp_blank();
        logic [80:0] b;
        for (int i = 0; i < 81; i++) b[i] = !m_given[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 81; i++) begin m_board[i] = 0; m_given[i] = 0; end
        m_sel = 0; m_row = 0; m_col = 0;
    endtask

    task automatic model_load(input logic [323:0] b, input logic [80:0] g);
        for (int i = 0; i < 81; i++) begin
            m_board[i] = (int'(b[i*4 +: 4]) > 9) ? 0 : int'(b[i*4 +: 4]);
            m_given[i] = g[i];
        end
        m_sel = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 81; i++) if (!m_given[i]) m_board[i] = 0;
    endtask

    task automatic model_click(input int x, input int y);
        int r, c;
        r = axis_cell(y, 1024);
        c = axis_cell(x, 480);
        if (r >= 0 && c >= 0) begin m_sel = 1; m_row = r; m_col = c; end
        else m_sel = 0;
    endtask

    function automatic bit model_write(input int d);
        int idx;
        idx = m_row * 9 + m_col;
        if (!m_given[idx] && d <= 9) begin m_board[idx] = d; return 1; end
        return 0;
    endfunction

    // ---------------- stimulus drivers ----------------
    task automatic drive_click(input int x, input int y);
        @(negedge clk);
        bus.mouse_x = 10'(x); bus.mouse_y = 10'(y); bus.click = 1'b1;
        @(negedge clk);
        bus.click = 1'b0;
    endtask

    task automatic wait_map();
        repeat (10) @(negedge clk);
    endtask

    task automatic drive_digit(input int d);
        @(negedge clk);
        bus.digit = 4'(d); bus.digit_valid = 1'b1;
        @(negedge clk);
        bus.digit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_load(input logic [323:0] b, input logic [80:0] g);
        @(negedge clk);
        bus.init_board = b; bus.init_given = g; bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        model_load(b, g);
    endtask

    task automatic drive_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_clear();
    endtask

    function automatic logic [323:0] rand_board();
        logic [323:0] b;
        for (int i = 0; i < 81; i++) b[i*4 +: 4] = 4'($urandom_range(0, 15));
        return b;
    endfunction

    function automatic logic [80:0] rand_given();
        logic [80:0] g;
        for (int i = 0; i < 81; i++) g[i] = ($urandom_range(0, 2) == 0);
        return g;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.board !== exp_board()) begin n_fail++; $display("FAIL reset_board: got %h expected %h", bus.board, exp_board()); end
        n_cmp++; if (bus.board_blank !== all_ones) begin n_fail++; $display("FAIL reset_blank: got %h expected %h", bus.board_blank, all_ones); end
        n_cmp++; if ({bus.sel_valid, bus.busy, bus.write_ack, bus.write_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.sel_valid, bus.busy, bus.write_ack, bus.write_err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_click_map();
        drive_click(110, 165);
        model_click(110, 165);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.busy !== 1'b1 || bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL map_busy[%0d]: got busy=%b sel=%b expected busy=1 sel=0", i, bus.busy, bus.sel_valid); end
            @(negedge clk);
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL map_busy_fall: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.sel_valid !== 1'b1 || bus.sel_row !== 4'd3 || bus.sel_col !== 4'd2) begin n_fail++; $display("FAIL map_sel: got v=%b r=%0d c=%0d expected v=1 r=3 c=2", bus.sel_valid, bus.sel_row, bus.sel_col); end
    endtask

    task automatic test_gap_offboard();
        drive_click(52, 10); wait_map(); model_click(52, 10);
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL gap_sel: got v=%b busy=%b expected v=0 busy=0", bus.sel_valid, bus.busy); end
        drive_digit(5);
        n_cmp++; if ({bus.write_ack, bus.write_err} !== 2'b00 || bus.board !== exp_board()) begin n_fail++; $display("FAIL idle_digit: got ack/err=%b expected 00 and board unchanged", {bus.write_ack, bus.write_err}); end
        drive_click(485, 10); wait_map(); model_click(485, 10);
        n_cmp++; if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL offboard_sel: got %b expected 0", bus.sel_valid); end
    endtask

    task automatic test_write();
        int ds [3] = '{7, 0, 12};
        bit ok;
        drive_click(110, 165); wait_map(); model_click(110, 165);
        foreach (ds[i]) begin
            drive_digit(ds[i]);
            ok = model_write(ds[i]);
            n_cmp++; if ({bus.write_ack, bus.write_err} !== {ok, !ok}) begin n_fail++; $display("FAIL write_pulse d=%0d: got ack/err=%b expected %b", ds[i], {bus.write_ack, bus.write_err}, {ok, !ok}); end
            n_cmp++; if (bus.board[29*4+3 -: 4] !== 4'(m_board[29])) begin n_fail++; $display("FAIL write_nibble d=%0d: got %0d expected %0d", ds[i], bus.board[29*4+3 -: 4], m_board[29]); end
            @(negedge clk);
            n_cmp++; if ({bus.write_ack, bus.write_err} !== 2'b00) begin n_fail++; $display("FAIL write_pulse_len d=%0d: got %b expected 00", ds[i], {bus.write_ack, bus.write_err}); end
        end
    endtask

    task automatic test_given_clear();
        logic [323:0] b;
        logic [80:0] g;
        b = rand_board(); g = rand_given();
        b[29*4 +: 4] = 4'd5; g[29] = 1'b1;
        drive_load(b, g);
        n_cmp++; if (bus.board !== exp_board() || bus.board_blank !== exp_blank()) begin n_fail++; $display("FAIL load: got %h expected %h", bus.board, exp_board()); end
        drive_click(110, 165); wait_map(); model_click(110, 165);
        drive_digit(4);
        n_cmp++; if ({bus.write_ack, bus.write_err} !== 2'b01 || bus.board[29*4+3 -: 4] !== 4'd5) begin n_fail++; $display("FAIL given_write: got ack/err=%b nib=%0d expected 01 nib=5", {bus.write_ack, bus.write_err}, bus.board[29*4+3 -: 4]); end
        drive_clear();
        n_cmp++; if (bus.board !== exp_board()) begin n_fail++; $display("FAIL clear_board: got %h expected %h", bus.board, exp_board()); end
        n_cmp++; if (bus.board[29*4+3 -: 4] !== 4'd5 || bus.sel_valid !== 1'b1) begin n_fail++; $display("FAIL clear_keep: got nib=%0d sel=%b expected nib=5 sel=1", bus.board[29*4+3 -: 4], bus.sel_valid); end
    endtask

    task automatic test_load_click_priority();
        logic [323:0] b;
        logic [80:0] g;
        b = rand_board(); g = rand_given();
        @(negedge clk);
        bus.mouse_x = 10'd110; bus.mouse_y = 10'd165; bus.click = 1'b1;
        bus.init_board = b; bus.init_given = g; bus.load_valid = 1'b1;
        @(negedge clk);
        bus.click = 1'b0; bus.load_valid = 1'b0;
        model_load(b, g);
        n_cmp++; if (bus.busy !== 1'b0 || bus.sel_valid !== 1'b0 || bus.board !== exp_board()) begin n_fail++; $display("FAIL load_prio: got busy=%b sel=%b expected busy=0 sel=0 and loaded board", bus.busy, bus.sel_valid); end
        repeat (11) @(negedge clk);
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL load_prio_nomap: got sel=%b busy=%b expected 0 0", bus.sel_valid, bus.busy); end
    endtask

    task automatic test_random();
        int op, x, y, d;
        bit ok;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            ok = 0;
            if (op <= 3) begin
                x = $urandom_range(0, 519); y = $urandom_range(0, 519);
                drive_click(x, y); wait_map(); model_click(x, y);
            end else if (op <= 7) begin
                d = $urandom_range(0, 11);
                drive_digit(d);
                if (m_sel) ok = model_write(d);
                n_cmp++; if ({bus.write_ack, bus.write_err} !== {m_sel && ok, m_sel && !ok}) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got %b expected %b", it, {bus.write_ack, bus.write_err}, {m_sel && ok, m_sel && !ok}); end
            end else if (op == 8) begin
                drive_clear();
            end else begin
                drive_load(rand_board(), rand_given());
            end
            n_cmp++; if (bus.board !== exp_board() || bus.board_blank !== exp_blank()) begin n_fail++; $display("FAIL rnd_board[%0d]: got %h expected %h", it, bus.board, exp_board()); end
            n_cmp++; if (bus.sel_valid !== m_sel || (m_sel && (bus.sel_row !== 4'(m_row) || bus.sel_col !== 4'(m_col)))) begin n_fail++; $display("FAIL rnd_sel[%0d]: got v=%b r=%0d c=%0d expected v=%b r=%0d c=%0d", it, bus.sel_valid, bus.sel_row, bus.sel_col, m_sel, m_row, m_col); end
        end
    endtask

    task automatic test_reset_mid_map();
        drive_click(110, 165);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b expected 1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (bus.busy !== 1'b0 || bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got busy=%b sel=%b expected 0 0", bus.busy, bus.sel_valid); end
        n_cmp++; if (bus.board !== exp_board() || bus.board_blank !== all_ones) begin n_fail++; $display("FAIL async_reset_board: got %h expected 0", bus.board); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got sel=%b busy=%b expected 0 0", bus.sel_valid, bus.busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.click = 1'b0; bus.mouse_x = 10'd0; bus.mouse_y = 10'd0;
        bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.clear = 1'b0;
        bus.load_valid = 1'b0; bus.init_board = '0; bus.init_given = '0;
        test_reset();
        test_click_map();
        test_gap_offboard();
        test_write();
        test_given_clear();
        test_load_click_priority();
        test_random();
        test_reset_mid_map();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
